painterengine_gpu_display_fetch: RTL and testbench

Frame-fetch sequencer for the GPU display path. It issues DMA reader bursts that stream a clipped framebuffer into the pixel FIFO, one line at a time. Unlike the single-shot streaming controller, it runs continuously: it re-arms on every frame-start pulse from the timing generator. It also supports parametrised burst and launch sizes and pixel sizes, a non-contiguous line stride, and front/back buffer swap at frame boundaries. Single clock domain; the FIFO free count arrives already synchronised.

---
 rtl/painterengine_gpu_display_fetch_if.sv | 25 ++
 rtl/painterengine_gpu_display_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_painterengine_gpu_display_fetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_display_fetch_if.sv
// Reader DMA bus between the display fetch sequencer and the burst reader.
// master: sequencer (drives address/length/resetn); slave: the DMA reader.
interface painterengine_gpu_display_fetch_if;
    logic [31:0] o_wire_reader_address;
    logic [31:0] o_wire_reader_length;
    logic        o_wire_reader_resetn;
    logic        i_wire_reader_done;
    logic        i_wire_reader_error;

    modport master (
        output o_wire_reader_address,
        output o_wire_reader_length,
        output o_wire_reader_resetn,
        input  i_wire_reader_done,
        input  i_wire_reader_error
    );

    modport slave (
        input  o_wire_reader_address,
        input  o_wire_reader_length,
        input  o_wire_reader_resetn,
        output i_wire_reader_done,
        output i_wire_reader_error
    );
endinterface

// File: rtl/painterengine_gpu_display_fetch.sv
// Frame-fetch sequencer: streams a clipped framebuffer, line by line, in DMA
// reader bursts; re-arms on every frame_start, with front/back buffer swap.
// Ports: i_wire_clock, i_wire_resetn (async, active-low), i_wire_enable,
//   i_wire_frame_start, i_wire_image_address/i_wire_swap_req (pending buffer),
//   i_wire_image_stride/clip_width/clip_height (latched per frame),
//   i_wire_fifo_free_count, reader (reader bus, master), o_wire_frame_done,
//   o_wire_state = {20'd0, retry[1:0], 4'd0, sticky_overrun, sticky_error,
//   state[3:0]}.
// Option: define GPU_DISPLAY_FETCH_RETRY_EN to retry a failed burst up to
//   three times before entering ERROR.
module painterengine_gpu_display_fetch #(
    parameter int PARAM_BURST_MAX   = 64,
    parameter int PARAM_LAUNCH_FREE = 48,
    parameter int PARAM_CNT_WIDTH   = 8,
    parameter int PARAM_BPP_BYTES   = 4
) (
    input  logic                       i_wire_clock,
    input  logic                       i_wire_resetn,
    input  logic                       i_wire_enable,
    input  logic                       i_wire_frame_start,
    input  logic [31:0]                i_wire_image_address,
    input  logic                       i_wire_swap_req,
    input  logic [15:0]                i_wire_image_stride,
    input  logic [15:0]                i_wire_clip_width,
    input  logic [15:0]                i_wire_clip_height,
    input  logic [PARAM_CNT_WIDTH-1:0] i_wire_fifo_free_count,
    painterengine_gpu_display_fetch_if.master reader,
    output logic                       o_wire_frame_done,
    output logic [31:0]                o_wire_state
);
    localparam int BPP_SHIFT = (PARAM_BPP_BYTES == 4) ? 2 :
                               (PARAM_BPP_BYTES == 2) ? 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_FRAME = 4'd1,
        S_CALC       = 4'd2,
        S_WAIT_SPACE = 4'd3,
        S_STREAM     = 4'd4,
        S_CHECK      = 4'd5,
        S_ERROR      = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_addr_q;
    logic [31:0] line_base_q;
    logic [31:0] addr_q;
    logic [15:0] len_q;
    logic [15:0] width_q, height_q, stride_q;
    logic [15:0] x_q, y_q;
    logic        frame_done_q;
    logic        sticky_err_q, sticky_ovr_q;
    logic [1:0]  retry_q;
    logic        retry_spent;

    function automatic logic [15:0] clamp_burst(input logic [15:0] n);
        return (32'(n) > 32'(PARAM_BURST_MAX)) ? 16'(PARAM_BURST_MAX) : n;
    endfunction

    // A swap on the same cycle as frame_start already applies to that frame.
    logic [31:0] eff_addr;
    logic        frame_go, overrun, restart, new_zero, space_ok;
    logic        err_in, done_in, line_done, frame_end;
    logic [15:0] y_inc;

    assign eff_addr  = i_wire_swap_req ? i_wire_image_address : pending_addr_q;
    assign err_in    = reader.i_wire_reader_error;
    assign done_in   = reader.i_wire_reader_done;
    assign frame_go  = i_wire_enable && i_wire_frame_start &&
                       (state_q == S_WAIT_FRAME || state_q == S_ERROR);
    assign overrun   = i_wire_enable && i_wire_frame_start &&
                       (state_q == S_CALC || state_q == S_WAIT_SPACE ||
                        state_q == S_STREAM || state_q == S_CHECK);
    assign restart   = frame_go || overrun;
    assign new_zero  = (i_wire_clip_width == 16'd0) ||
                       (i_wire_clip_height == 16'd0);
    assign space_ok  = 32'(i_wire_fifo_free_count) >= 32'(PARAM_LAUNCH_FREE);
    assign line_done = (x_q == width_q);
    assign y_inc     = y_q + 16'd1;
    assign frame_end = line_done && (y_inc == height_q);

`ifdef GPU_DISPLAY_FETCH_RETRY_EN
    assign retry_spent = (retry_q == 2'd3);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            retry_q <= 2'd0;
        end else if (restart) begin
            retry_q <= 2'd0;
        end else if (i_wire_enable && state_q == S_STREAM) begin
            if (err_in) begin
                if (!retry_spent) retry_q <= retry_q + 2'd1;
            end else if (done_in) begin
                retry_q <= 2'd0;
            end
        end
    end
`else
    assign retry_spent = 1'b1;
    assign retry_q     = 2'd0;
`endif

    // State register
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Next state. An overrun skips CALC so the reader is down for one cycle
    // only (its first burst is computed inline, x being 0).
    always_comb begin
        state_d = state_q;
        if (!i_wire_enable) begin
            state_d = S_IDLE;
        end else if (restart) begin
            if (new_zero)     state_d = S_WAIT_FRAME;
            else if (overrun) state_d = S_WAIT_SPACE;
            else              state_d = S_CALC;
        end else begin
            unique case (state_q)
                S_IDLE:       state_d = S_WAIT_FRAME;
                S_WAIT_FRAME: state_d = S_WAIT_FRAME;
                S_CALC:       state_d = S_WAIT_SPACE;
                S_WAIT_SPACE: if (space_ok) state_d = S_STREAM;
                S_STREAM: begin
                    if (err_in)
                        state_d = retry_spent ? S_ERROR : S_WAIT_SPACE;
                    else if (done_in)
                        state_d = S_CHECK;
                end
                S_CHECK:      state_d = frame_end ? S_WAIT_FRAME : S_CALC;
                S_ERROR:      state_d = S_ERROR;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: frame geometry, line walk, burst registers and flags.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            pending_addr_q <= 32'd0;
            line_base_q    <= 32'd0;
            addr_q         <= 32'd0;
            len_q          <= 16'd0;
            width_q        <= 16'd0;
            height_q       <= 16'd0;
            stride_q       <= 16'd0;
            x_q            <= 16'd0;
            y_q            <= 16'd0;
            frame_done_q   <= 1'b0;
            sticky_err_q   <= 1'b0;
            sticky_ovr_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (i_wire_swap_req) pending_addr_q <= i_wire_image_address;
            if (restart) begin
                width_q     <= i_wire_clip_width;
                height_q    <= i_wire_clip_height;
                stride_q    <= i_wire_image_stride;
                x_q         <= 16'd0;
                y_q         <= 16'd0;
                line_base_q <= eff_addr;
                if (overrun) sticky_ovr_q <= 1'b1;
                if (new_zero) begin
                    frame_done_q <= 1'b1;
                end else if (overrun) begin
                    addr_q <= eff_addr;
                    len_q  <= clamp_burst(i_wire_clip_width);
                end
            end else if (i_wire_enable) begin
                unique case (state_q)
                    S_CALC: begin
                        addr_q <= line_base_q + (32'(x_q) << BPP_SHIFT);
                        len_q  <= clamp_burst(width_q - x_q);
                    end
                    S_STREAM: begin
                        if (err_in) begin
                            if (retry_spent) sticky_err_q <= 1'b1;
                        end else if (done_in) begin
                            x_q <= x_q + len_q;
                        end
                    end
                    S_CHECK: begin
                        if (line_done) begin
                            x_q         <= 16'd0;
                            y_q         <= y_inc;
                            line_base_q <= line_base_q +
                                           (32'(stride_q) << BPP_SHIFT);
                            if (frame_end) frame_done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        reader.o_wire_reader_resetn  = (state_q == S_STREAM);
        reader.o_wire_reader_address = addr_q;
        reader.o_wire_reader_length  = {16'd0, len_q};
        o_wire_frame_done            = frame_done_q;
        o_wire_state = {20'd0, retry_q, 4'd0,
                        sticky_ovr_q, sticky_err_q, state_q};
    end
endmodule

// File: tb/tb_painterengine_gpu_display_fetch.sv
// Scoreboard bench for painterengine_gpu_display_fetch: stimulus pushes
// expected bursts/frame-done events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_painterengine_gpu_display_fetch;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        swap_req = 1'b0;
    logic [31:0] image_address = 32'd0;
    logic [15:0] stride = 16'd0;
    logic [15:0] width = 16'd0;
    logic [15:0] height = 16'd0;
    logic [7:0]  free_count = 8'd0;
    logic        frame_done;
    logic [31:0] state_word;

    painterengine_gpu_display_fetch_if bus();

    painterengine_gpu_display_fetch dut (
        .i_wire_clock           (clk),
        .i_wire_resetn          (rstn),
        .i_wire_enable          (enable),
        .i_wire_frame_start     (frame_start),
        .i_wire_image_address   (image_address),
        .i_wire_swap_req        (swap_req),
        .i_wire_image_stride    (stride),
        .i_wire_clip_width      (width),
        .i_wire_clip_height     (height),
        .i_wire_fifo_free_count (free_count),
        .reader                 (bus.master),
        .o_wire_frame_done      (frame_done),
        .o_wire_state           (state_word)
    );

    always #5 clk = ~clk;

`ifdef GPU_DISPLAY_FETCH_RETRY_EN
    localparam logic [31:0] ERR_BIT = 32'h0;
`else
    localparam logic [31:0] ERR_BIT = 32'h10;
`endif

    typedef struct packed {
        logic        fd;
        logic [31:0] addr;
        logic [31:0] len;
    } ev_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];
    int   passed = 0;
    int   total = 0;
    logic prev_rn = 1'b0;

    // Monitor: all comparisons and counters live here.
    always @(negedge clk) begin
        ev_t  e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            total++;
            if (c.act === c.exp) passed++;
            else $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
        end
        if (rstn && bus.o_wire_reader_resetn && !prev_rn) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL burst: got %h/%0d expected none",
                         bus.o_wire_reader_address, bus.o_wire_reader_length);
            end else begin
                e = exp_q.pop_front();
                if (!e.fd && e.addr === bus.o_wire_reader_address &&
                    e.len === bus.o_wire_reader_length)
                    passed++;
                else
                    $display("FAIL burst: got %h/%0d expected %h/%0d fd=%0b",
                             bus.o_wire_reader_address,
                             bus.o_wire_reader_length, e.addr, e.len, e.fd);
            end
        end
        if (rstn && frame_done) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL frame_done: got pulse expected none");
            end else begin
                e = exp_q.pop_front();
                if (e.fd) passed++;
                else $display("FAIL frame_done: got pulse expected burst %h/%0d",
                              e.addr, e.len);
            end
        end
        prev_rn = bus.o_wire_reader_resetn;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic burst(input logic [31:0] a, input logic [31:0] l);
        exp_q.push_back({1'b0, a, l});
    endtask

    task automatic fdone();
        exp_q.push_back({1'b1, 64'd0});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stream();
        for (int i = 0; i < 200 && !bus.o_wire_reader_resetn; i++)
            @(negedge clk);
        chk("stream_wait", 32'(bus.o_wire_reader_resetn), 32'd1);
    endtask

    task automatic pulse_done();
        bus.i_wire_reader_done = 1'b1;
        cyc(1);
        bus.i_wire_reader_done = 1'b0;
    endtask

    task automatic pulse_error();
        bus.i_wire_reader_error = 1'b1;
        cyc(1);
        bus.i_wire_reader_error = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic swap(input logic [31:0] a);
        image_address = a;
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
    endtask

    task automatic bursts(input int n);
        repeat (n) begin
            wait_stream();
            pulse_done();
        end
    endtask

    initial begin
        bus.i_wire_reader_done  = 1'b0;
        bus.i_wire_reader_error = 1'b0;
        cyc(2);
        chk("rst_state", state_word, 32'h0);
        chk("rst_rn", 32'(bus.o_wire_reader_resetn), 32'h0);
        chk("rst_addr", bus.o_wire_reader_address, 32'h0);
        chk("rst_len", bus.o_wire_reader_length, 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rstn = 1'b1;
        enable = 1'b1;
        free_count = 8'd128;
        cyc(2);
        chk("enable_state", state_word, 32'h1);

        // Basic frame
        width = 16'd100;
        height = 16'd2;
        stride = 16'd128;
        swap(32'h1000);
        burst(32'h1000, 64); burst(32'h1100, 36);
        burst(32'h1200, 64); burst(32'h1300, 36); fdone();
        pulse_start();
        bursts(4);
        cyc(3);
        chk("frame1_state", state_word, 32'h1);
        chk("frame1_drain", exp_q.size(), 0);

        // Back-pressure, then a mid-frame swap
        free_count = 8'd47;
        burst(32'h1000, 64); burst(32'h1100, 36);
        burst(32'h1200, 64); burst(32'h1300, 36); fdone();
        pulse_start();
        cyc(4);
        chk("bp_state", state_word, 32'h3);
        chk("bp_rn", 32'(bus.o_wire_reader_resetn), 32'h0);
        free_count = 8'd48;
        cyc(1);
        chk("bp_go_state", state_word, 32'h4);
        chk("bp_go_rn", 32'(bus.o_wire_reader_resetn), 32'h1);
        pulse_done();
        swap(32'h8000);
        height = 16'd1;
        bursts(3);
        cyc(3);
        chk("swap_cur_drain", exp_q.size(), 0);
        burst(32'h8000, 64); burst(32'h8100, 36); fdone();
        pulse_start();
        bursts(2);
        cyc(3);
        chk("swap_next_drain", exp_q.size(), 0);

        // Zero-size frame
        width = 16'd0;
        fdone();
        pulse_start();
        chk("zero_fd", 32'(frame_done), 32'h1);
        cyc(1);
        chk("zero_fd_pulse", 32'(frame_done), 32'h0);
        chk("zero_state", state_word, 32'h1);
        cyc(4);

        // Error on the second burst
        width = 16'd100;
        burst(32'h8000, 64); burst(32'h8100, 36);
`ifdef GPU_DISPLAY_FETCH_RETRY_EN
        burst(32'h8100, 36); burst(32'h8100, 36); burst(32'h8100, 36);
        fdone();
`endif
        pulse_start();
        wait_stream();
        pulse_done();
        wait_stream();
`ifdef GPU_DISPLAY_FETCH_RETRY_EN
        repeat (3) begin
            pulse_error();
            wait_stream();
        end
        chk("retry_count", state_word, 32'hC04);
        pulse_done();
        cyc(3);
        chk("retry_recover", state_word, 32'h1);
`else
        pulse_error();
        chk("error_state", state_word, 32'h17);
        cyc(3);
        chk("error_hold", state_word, 32'h17);
        chk("error_rn", 32'(bus.o_wire_reader_resetn), 32'h0);
`endif

        // Overrun during STREAM
        height = 16'd2;
        burst(32'h8000, 64);
        pulse_start();
        wait_stream();
        burst(32'h8000, 64); burst(32'h8100, 36);
        burst(32'h8200, 64); burst(32'h8300, 36); fdone();
        pulse_start();
        chk("ovr_rn_low", 32'(bus.o_wire_reader_resetn), 32'h0);
        chk("ovr_state", state_word, 32'h23 | ERR_BIT);
        cyc(1);
        chk("ovr_rn_high", 32'(bus.o_wire_reader_resetn), 32'h1);
        bursts(4);
        cyc(3);
        chk("ovr_done_state", state_word, 32'h21 | ERR_BIT);

        // Disable keeps sticky flags
        enable = 1'b0;
        cyc(2);
        chk("disable_state", state_word, 32'h20 | ERR_BIT);
        chk("disable_rn", 32'(bus.o_wire_reader_resetn), 32'h0);
        chk("final_drain", exp_q.size(), 0);
        cyc(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
